// File: rtl/req_scheduler.sv
// Latches one request ID from the inbound FIFO and offers it to two channels,
// each with its own valid/ready handshake, while counting dispatches and drops.
module req_scheduler #(
  parameter int REQ_ID_WIDTH = 32,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ignore_rx,
  input  logic [1:0]              ch_enable,
  input  logic [REQ_ID_WIDTH-1:0] FIFO_TDATA,
  input  logic                    FIFO_TVALID,
  output logic                    FIFO_TREADY,
  output logic [REQ_ID_WIDTH-1:0] ch0_req_id,
  output logic [REQ_ID_WIDTH-1:0] ch1_req_id,
  output logic                    ch0_req_valid,
  output logic                    ch1_req_valid,
  input  logic                    ch0_req_ready,
  input  logic                    ch1_req_ready,
  output logic [CNT_WIDTH-1:0]    dispatch_count,
  output logic [CNT_WIDTH-1:0]    drop_count,
  output logic                    busy,
  output logic                    state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends combinationally on ready, and FIFO_TREADY is a pure
  // function of state.
  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [REQ_ID_WIDTH-1:0] req_id_reg, req_id_nxt;
  logic [1:0]              pend, pend_nxt;
  logic [1:0]              hs;
  logic [CNT_WIDTH-1:0]    dispatch_cnt;
  logic [CNT_WIDTH-1:0]    drop_cnt;
  logic                    dispatch_inc;
  logic                    drop_inc;

  assign hs = pend & {ch1_req_ready, ch0_req_ready};

  always_comb begin
    state_nxt    = state;
    req_id_nxt   = req_id_reg;
    pend_nxt     = pend;
    dispatch_inc = 1'b0;
    drop_inc     = 1'b0;
    case (state)
      S_IDLE: begin
        if (FIFO_TVALID) begin
          if (ignore_rx || (ch_enable == 2'b00)) begin
            drop_inc = 1'b1;
          end else begin
            req_id_nxt = FIFO_TDATA;
            pend_nxt   = ch_enable;
            state_nxt  = S_PRESENT;
          end
        end
      end
      S_PRESENT: begin
        // Channels that already accepted have pend low, so their ready is masked.
        pend_nxt = pend & ~hs;
        if (pend_nxt == 2'b00) begin
          dispatch_inc = 1'b1;
          state_nxt    = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        pend_nxt  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      req_id_reg   <= '0;
      pend         <= 2'b00;
      dispatch_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      req_id_reg <= req_id_nxt;
      pend       <= pend_nxt;
      if (dispatch_inc) dispatch_cnt <= dispatch_cnt + 1'b1;
      if (drop_inc)     drop_cnt     <= drop_cnt + 1'b1;
    end
  end

  assign FIFO_TREADY    = (state == S_IDLE);
  assign busy           = (state == S_PRESENT);
  assign state_dbg      = state;
  assign ch0_req_valid  = pend[0];
  assign ch1_req_valid  = pend[1];
  assign ch0_req_id     = req_id_reg;
  assign ch1_req_id     = req_id_reg;
  assign dispatch_count = dispatch_cnt;
  assign drop_count     = drop_cnt;

endmodule
